// File: rtl/sha1_pad.sv
`default_nettype none
// ============================================================================
// Module   : sha1_pad
// Purpose  : Packs a big-endian byte stream into 32-bit words and appends
//            SHA-1 padding (0x80, zero fill, 64-bit bit length).
// Revision : 1.0
// ============================================================================
module sha1_pad #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_keep,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_msg_last,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_DATA   = 2'd0,
        S_PAD    = 2'd1,
        S_LEN_HI = 2'd2,
        S_LEN_LO = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [23:0]            asm_q, asm_d;
    logic [1:0]             pos_q, pos_d;
    logic [CNT_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic                   pend_q, pend_d;
    logic                   out_valid_q, out_valid_d;
    logic [31:0]            out_data_q, out_data_d;
    logic [3:0]             out_idx_q, out_idx_d;
    logic                   out_msg_last_q, out_msg_last_d;
    logic                   busy_q, busy_d;

    logic                   take, can_load, accept;
    logic [3:0]             load_idx;
    logic                   ld, ld_last;
    logic [31:0]            ld_word, word_cat, word_term;
    logic [2:0]             fill;
    logic [63:0]            bitlen;

    always_comb begin
        state_d        = state_q;
        asm_d          = asm_q;
        pos_d          = pos_q;
        byte_cnt_d     = byte_cnt_q;
        pend_d         = pend_q;
        busy_d         = busy_q;
        ld             = 1'b0;
        ld_last        = 1'b0;
        ld_word        = 32'h0;

        take     = out_valid_q & out_ready;
        can_load = ~out_valid_q | out_ready;
        load_idx = out_idx_q + {3'b000, take};
        in_ready = (state_q == S_DATA) && !pend_q && can_load;
        accept   = in_valid & in_ready;
        bitlen   = {{(61-CNT_WIDTH){1'b0}}, byte_cnt_q, 3'b000};

        // Unfilled byte lanes of asm_q are always zero, so merging is a plain write.
        word_cat = {asm_q, 8'h00};
        if (in_keep) begin
            case (pos_q)
                2'd0:    word_cat[31:24] = in_data;
                2'd1:    word_cat[23:16] = in_data;
                2'd2:    word_cat[15:8]  = in_data;
                default: word_cat[7:0]   = in_data;
            endcase
        end
        fill      = {1'b0, pos_q} + {2'b00, in_keep};
        word_term = word_cat;
        case (fill)
            3'd0:    word_term[31:24] = 8'h80;
            3'd1:    word_term[23:16] = 8'h80;
            3'd2:    word_term[15:8]  = 8'h80;
            3'd3:    word_term[7:0]   = 8'h80;
            default: ;
        endcase

        case (state_q)
            S_DATA: begin
                if (pend_q) begin
                    if (can_load) begin
                        ld      = 1'b1;
                        ld_word = 32'h8000_0000;
                        pend_d  = 1'b0;
                        state_d = (load_idx == 4'd13) ? S_LEN_HI : S_PAD;
                    end
                end else if (accept) begin
                    if (in_keep)
                        byte_cnt_d = byte_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                    if (in_last) begin
                        asm_d = 24'h0;
                        pos_d = 2'd0;
                        ld    = 1'b1;
                        if (fill == 3'd4) begin
                            ld_word = word_cat;
                            pend_d  = 1'b1;
                        end else begin
                            ld_word = word_term;
                            state_d = (load_idx == 4'd13) ? S_LEN_HI : S_PAD;
                        end
                    end else if (in_keep) begin
                        if (pos_q == 2'd3) begin
                            ld      = 1'b1;
                            ld_word = word_cat;
                            asm_d   = 24'h0;
                            pos_d   = 2'd0;
                        end else begin
                            asm_d = word_cat[31:8];
                            pos_d = pos_q + 2'd1;
                        end
                    end
                end
            end
            S_PAD: begin
                if (can_load) begin
                    ld = 1'b1;
                    if (load_idx == 4'd13)
                        state_d = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (can_load) begin
                    ld      = 1'b1;
                    ld_word = bitlen[63:32];
                    state_d = S_LEN_LO;
                end
            end
            default: begin
                if (can_load) begin
                    ld         = 1'b1;
                    ld_word    = bitlen[31:0];
                    ld_last    = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_DATA;
                end
            end
        endcase

        out_valid_d    = out_valid_q & ~take;
        out_data_d     = out_data_q;
        out_msg_last_d = out_msg_last_q & ~take;
        out_idx_d      = load_idx;
        if (ld) begin
            out_valid_d    = 1'b1;
            out_data_d     = ld_word;
            out_msg_last_d = ld_last;
        end

        if (take && out_msg_last_q)
            busy_d = 1'b0;
        if (accept && (in_keep || in_last))
            busy_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q        <= S_DATA;
            asm_q          <= 24'h0;
            pos_q          <= 2'd0;
            byte_cnt_q     <= '0;
            pend_q         <= 1'b0;
            out_valid_q    <= 1'b0;
            out_data_q     <= 32'h0;
            out_idx_q      <= 4'd0;
            out_msg_last_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            asm_q          <= asm_d;
            pos_q          <= pos_d;
            byte_cnt_q     <= byte_cnt_d;
            pend_q         <= pend_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_idx_q      <= out_idx_d;
            out_msg_last_q <= out_msg_last_d;
            busy_q         <= busy_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_idx      = out_idx_q;
    assign out_msg_last = out_msg_last_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sha1_pad.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_pad
// Purpose  : Scoreboard bench for sha1_pad against a byte-level padding model.
// Revision : 1.0
// ============================================================================
module tb_sha1_pad;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        in_keep = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_msg_last;
    logic        busy;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    bit          bp = 1'b0;
    bit          ign = 1'b0;

    sha1_pad #(.CNT_WIDTH(32)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_keep      (in_keep),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_idx      (out_idx),
        .out_msg_last (out_msg_last),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: standard SHA-1 padding computed on the whole byte string.
    task automatic expect_msg(input byte_q_t m);
        byte_q_t     p;
        logic [63:0] bl;
        int          n;
        exp_t        e;
        p  = m;
        bl = 64'(m.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        n = p.size() / 4;
        for (int w = 0; w < n; w++) begin
            e.d = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.i = 4'(w % 16);
            e.l = (w == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        bit done;
        bit rdy;
        done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        for (int c = 0; c < 500 && !done; c++) begin
            #4;
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL beat_accept: in_ready never 1 within 500 cycles, expected 1");
        end
    endtask

    task automatic send_msg(input byte_q_t m, input bit last_on_byte);
        bit lob;
        lob = last_on_byte && (m.size() > 0);
        expect_msg(m);
        for (int k = 0; k < m.size(); k++) begin
            if (ign && ($urandom % 8 == 0)) send_beat(8'($urandom), 1'b0, 1'b0);
            if (ign && ($urandom % 4 == 0)) @(negedge clk);
            send_beat(m[k], 1'b1, lob && (k == m.size() - 1));
        end
        if (!lob) send_beat(8'($urandom), 1'b0, 1'b1);
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (sb.size() != 0 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        if (sb.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain: %0d words still owed, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    function automatic byte_q_t ramp(input int n);
        byte_q_t q;
        for (int k = 0; k < n; k++) q.push_back(8'(k + 1));
        return q;
    endfunction

    // Monitor: drives back-pressure, pops the scoreboard on each handshake.
    logic [31:0] st_d;
    logic [3:0]  st_i;
    logic        st_l;
    bit          st_v = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        out_ready = bp ? ($urandom % 3 != 0) : 1'b1;
        #4;
        if (!rst_n) begin
            st_v = 1'b0;
        end else begin
            if (st_v && out_valid) begin
                check("stall_data", out_data, st_d);
                check("stall_idx", 32'(out_idx), 32'(st_i));
                check("stall_last", 32'(out_msg_last), 32'(st_l));
            end
            st_v = 1'b0;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                st_v = 1'b1; st_d = out_data; st_i = out_idx; st_l = out_msg_last;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL extra_word: got %h idx %0d, expected no word", out_data, out_idx);
                end else begin
                    e = sb.pop_front();
                    check("word_data", out_data, e.d);
                    check("word_idx", 32'(out_idx), 32'(e.i));
                    check("word_last", 32'(out_msg_last), 32'(e.l));
                end
            end
        end
    end

    initial begin
        byte_q_t m;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_msg_last", 32'(out_msg_last), 32'd0);

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1);           drain();
        m = {};
        send_msg(m, 1'b0);           drain();
        send_msg(ramp(55), 1'b1);    drain();
        send_msg(ramp(56), 1'b1);    drain();
        send_msg(ramp(64), 1'b0);    drain();

        bp = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1);           drain();
        send_msg(ramp(56), 1'b1);    drain();
        bp = 1'b0;

        // Reset while padding is in flight.
        send_msg(ramp(20), 1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_out_data", out_data, 32'd0);
        check("async_rst_out_idx", 32'(out_idx), 32'd0);
        check("async_rst_msg_last", 32'(out_msg_last), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b1);           drain();

        bp  = 1'b1;
        ign = 1'b1;
        for (int r = 0; r < 25; r++) begin
            m = {};
            for (int k = 0; k < $urandom_range(0, 140); k++) m.push_back(8'($urandom));
            send_msg(m, 1'($urandom));
            if ($urandom % 2 == 0) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
